// File: rtl/run_length_monitor_pkg.sv
// Shared types and helpers for the run length monitor.
`timescale 1ns/1ps
package run_length_pkg;

    // Widest counter the helper function supports.
    localparam int MAX_COUNT_WIDTH = 32;

    // Run-tracking states: idle, counting, held at the maximum.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } rl_state_t;

    // Next counter value. At max_val the count either stays there (saturate)
    // or returns to zero (wrap).
    // The caller narrows the result to its own width.
    // The max test compares against the all-ones value passed in.
    // It does not rely on a carry out of the adder.
    function automatic logic [MAX_COUNT_WIDTH-1:0] next_count(
        input logic [MAX_COUNT_WIDTH-1:0] count,
        input logic [MAX_COUNT_WIDTH-1:0] max_val,
        input logic                       wrap
    );
        if (count == max_val) begin
            return wrap ? '0 : max_val;
        end
        return count + 1'b1;
    endfunction

endpackage

// File: rtl/run_length_monitor_if.sv
// Signal bundle between the run length monitor and its driver/observer.
`timescale 1ns/1ps
interface run_length_monitor_if #(
    parameter int WIDTH = 2
);
    logic             clr;
    logic             b;
    logic [WIDTH-1:0] y;
    logic             hit;
    logic             sat;
    logic [WIDTH-1:0] len;
    logic             len_vld;

    modport master (
        output clr, b,
        input  y, hit, sat, len, len_vld
    );

    modport slave (
        input  clr, b,
        output y, hit, sat, len, len_vld
    );
endinterface

// File: rtl/run_length_monitor.sv
// Counts consecutive high cycles of a serial input.
// It flags a threshold crossing and saturation.
// It also reports the length of each completed run.
`timescale 1ns/1ps
module run_length_monitor #(
    parameter int WIDTH  = 2,
    parameter int THRESH = 3,
    parameter int WRAP   = 0
) (
    input  logic                clk,
    input  logic                rst,
    run_length_monitor_if.slave bus
);
    import run_length_pkg::*;

    if (WIDTH < 1 || WIDTH > MAX_COUNT_WIDTH) begin : g_width_check
        $error("run_length_monitor: WIDTH must be between 1 and %0d", MAX_COUNT_WIDTH);
    end

    if (THRESH < 1 || longint'(THRESH) > ((longint'(1) << WIDTH) - 1)) begin : g_thresh_check
        $error("run_length_monitor: THRESH must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX     = '1;
    localparam logic [WIDTH-1:0] THR     = WIDTH'(THRESH);
    localparam logic             WRAP_EN = (WRAP != 0);

    rl_state_t        state, state_n;
    logic [WIDTH-1:0] y_q, y_n;
    logic [WIDTH-1:0] len_q, len_n;
    logic             hit_q, hit_n;
    logic             sat_q, sat_n;
    logic             vld_q, vld_n;

    // State and every output are registered; reset clears them immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            y_q   <= '0;
            len_q <= '0;
            hit_q <= 1'b0;
            sat_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            state <= state_n;
            y_q   <= y_n;
            len_q <= len_n;
            hit_q <= hit_n;
            sat_q <= sat_n;
            vld_q <= vld_n;
        end
    end

    // Next state and outputs. Priority is clr, then b.
    // A run ends on a low b; the length is captured from the pre-edge count.
    always_comb begin
        state_n = state;
        y_n     = y_q;
        len_n   = len_q;
        hit_n   = 1'b0;
        vld_n   = 1'b0;

        if (bus.clr) begin
            state_n = IDLE;
            y_n     = '0;
        end else if (bus.b) begin
            if (state != SAT) begin
                y_n     = WIDTH'(next_count(MAX_COUNT_WIDTH'(y_q), MAX_COUNT_WIDTH'(MAX), WRAP_EN));
                hit_n   = (y_n == THR);
                state_n = (!WRAP_EN && y_n == MAX) ? SAT : RUN;
            end
        end else if (state != IDLE) begin
            len_n   = y_q;
            vld_n   = 1'b1;
            y_n     = '0;
            state_n = IDLE;
        end

        sat_n = (state_n == SAT);
    end

    assign bus.y       = y_q;
    assign bus.hit     = hit_q;
    assign bus.sat     = sat_q;
    assign bus.len     = len_q;
    assign bus.len_vld = vld_q;

endmodule

// File: tb/tb_run_length_monitor.sv
// Scoreboard bench for run_length_monitor: a saturating and a wrapping instance.
`timescale 1ns/1ps
module tb_run_length_monitor;

    typedef struct packed {
        logic [1:0] y;
        logic       hit;
        logic       sat;
        logic [1:0] len;
        logic       len_vld;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    always #20 clk = ~clk;

    run_length_monitor_if #(.WIDTH(2)) bus0 ();
    run_length_monitor_if #(.WIDTH(2)) bus1 ();

    run_length_monitor #(.WIDTH(2), .THRESH(3), .WRAP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    run_length_monitor #(.WIDTH(2), .THRESH(3), .WRAP(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    function automatic obs_t mk(input int y, input int hit, input int sat, input int len, input int vld);
        obs_t o;
        o.y       = 2'(y);
        o.hit     = 1'(hit);
        o.sat     = 1'(sat);
        o.len     = 2'(len);
        o.len_vld = 1'(vld);
        return o;
    endfunction

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.y = bus0.y; o.hit = bus0.hit; o.sat = bus0.sat; o.len = bus0.len; o.len_vld = bus0.len_vld;
        end else begin
            o.y = bus1.y; o.hit = bus1.hit; o.sat = bus1.sat; o.len = bus1.len; o.len_vld = bus1.len_vld;
        end
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("y=%0d hit=%b sat=%b len=%0d len_vld=%b", o.y, o.hit, o.sat, o.len, o.len_vld);
    endfunction

    // Drive one input pair on the falling edge; return just after the next rising edge.
    task automatic drive_cycle(input int sel, input logic c, input logic bb);
        @(negedge clk);
        if (sel == 0) begin
            bus0.clr = c; bus0.b = bb;
        end else begin
            bus1.clr = c; bus1.b = bb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        bus0.clr = 1'b0; bus0.b = 1'b0;
        bus1.clr = 1'b0; bus1.b = 1'b0;
        #5 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_q.push_back(mk(0, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0));
            got = sample(0); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset_sat_dut cycle %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
            got = sample(1); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset_wrap_dut cycle %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_saturate();
        logic b_seq [6];
        obs_t want_tbl [6];
        obs_t got, want;
        b_seq    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        want_tbl = '{mk(1,0,0,0,0), mk(2,0,0,0,0), mk(3,1,1,0,0),
                     mk(3,0,1,0,0), mk(0,0,0,3,1), mk(0,0,0,3,0)};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(want_tbl[i]);
            drive_cycle(0, 1'b0, b_seq[i]);
            got = sample(0); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL saturate step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_short_run();
        logic b_seq [4];
        obs_t want_tbl [4];
        obs_t got, want;
        b_seq    = '{1'b1, 1'b1, 1'b0, 1'b0};
        want_tbl = '{mk(1,0,0,3,0), mk(2,0,0,3,0), mk(0,0,0,2,1), mk(0,0,0,2,0)};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(want_tbl[i]);
            drive_cycle(0, 1'b0, b_seq[i]);
            got = sample(0); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL short_run step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_clear();
        logic c_seq [6];
        logic b_seq [6];
        obs_t want_tbl [6];
        obs_t got, want;
        c_seq    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        b_seq    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        want_tbl = '{mk(1,0,0,2,0), mk(2,0,0,2,0), mk(0,0,0,2,0),
                     mk(0,0,0,2,0), mk(1,0,0,2,0), mk(0,0,0,1,1)};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(want_tbl[i]);
            drive_cycle(0, c_seq[i], b_seq[i]);
            got = sample(0); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL clear step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic b_seq [6];
        obs_t want_tbl [6];
        obs_t got, want;
        b_seq    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        want_tbl = '{mk(1,0,0,1,0), mk(2,0,0,1,0), mk(0,0,0,2,1),
                     mk(1,0,0,2,0), mk(0,0,0,1,1), mk(0,0,0,1,0)};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(want_tbl[i]);
            drive_cycle(0, 1'b0, b_seq[i]);
            got = sample(0); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL back_to_back step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_wrap();
        logic b_seq [6];
        obs_t want_tbl [6];
        obs_t got, want;
        b_seq    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        want_tbl = '{mk(1,0,0,0,0), mk(2,0,0,0,0), mk(3,1,0,0,0),
                     mk(0,0,0,0,0), mk(1,0,0,0,0), mk(0,0,0,1,1)};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(want_tbl[i]);
            drive_cycle(1, 1'b0, b_seq[i]);
            got = sample(1); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL wrap step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_wrap_refire();
        logic b_seq [8];
        obs_t want_tbl [8];
        obs_t got, want;
        b_seq    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        want_tbl = '{mk(1,0,0,1,0), mk(2,0,0,1,0), mk(3,1,0,1,0), mk(0,0,0,1,0),
                     mk(1,0,0,1,0), mk(2,0,0,1,0), mk(3,1,0,1,0), mk(0,0,0,3,1)};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(want_tbl[i]);
            drive_cycle(1, 1'b0, b_seq[i]);
            got = sample(1); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL wrap_refire step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got, want;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(i + 1, 0, 0, 1, 0));
            drive_cycle(0, 1'b0, 1'b1);
            got = sample(0); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL async_reset_prerun step %0d: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
        #9 rst = 1'b0;
        #5;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        got = sample(0); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL async_reset_clear: got %s, want %s", fmt(got), fmt(want));
        end
        #15 rst = 1'b1;
        exp_q.push_back(mk(1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        got = sample(0); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL async_reset_restart: got %s, want %s", fmt(got), fmt(want));
        end
        exp_q.push_back(mk(0, 0, 0, 1, 1));
        drive_cycle(0, 1'b0, 1'b0);
        got = sample(0); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL async_reset_len: got %s, want %s", fmt(got), fmt(want));
        end
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_short_run();
        test_clear();
        test_back_to_back();
        test_wrap();
        test_wrap_refire();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
